xclk_multi_divider: RTL and testbench

- Parametrised, multi-channel successor to the fixed sensor XCLK generator.
- Produces NUM_CH independent divided clocks from i_Clk, each with a 50% duty cycle and a runtime-programmable divide ratio.
- Divide-ratio changes and enable changes are glitch-free.
- Per channel it provides a one-cycle rising-edge strobe and a ready flag (the counterpart of PLL lock).
- Drives the OV7670 XCLK and slower housekeeping clocks or enables (SCCB bit timing, frame-rate test patterns).

---
 rtl/xclk_multi_divider.sv | 131 +++++++++++++
 tb/tb_xclk_multi_divider.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/xclk_multi_divider.sv
// Multi-channel 50%-duty clock divider with glitch-free ratio/enable changes,
// a per-channel rising-edge strobe and a ready flag once the output has settled.
module xclk_multi_divider #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 0,
  parameter int READY_EDGES = 2
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_CH-1:0]       i_Enable,
  input  logic [NUM_CH-1:0]       i_Load,
  input  logic [NUM_CH*CNT_W-1:0] i_Div,
  output logic [NUM_CH-1:0]       o_Clk,
  output logic [NUM_CH-1:0]       o_Tick,
  output logic [NUM_CH-1:0]       o_Ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0]       READY_CNT = 4'(READY_EDGES);
  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DEFAULT_DIV);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [3:0]       edge_q, edge_d;
    logic             wrap;
    logic             apply;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      div_act_d = div_act_q;
      edge_d    = edge_q;
      apply     = 1'b0;
      wrap      = (cnt_q == div_act_q);

      unique case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          clk_d  = 1'b0;
          edge_d = '0;
          if (i_Enable[n]) begin
            state_d = ST_RUN;
            apply   = pend_q;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (state_q == ST_RUN && !i_Enable[n] && !clk_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            edge_d  = '0;
          end else begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
              clk_d = ~clk_q;
              if (!clk_q) begin
                tick_d = 1'b1;
                if (edge_q != READY_CNT) edge_d = edge_q + 1'b1;
              end else begin
                // End of a high phase: the only point where ratio or run state may change.
                apply = pend_q;
                if (i_Enable[n]) begin
                  state_d = ST_RUN;
                end else begin
                  state_d = ST_IDLE;
                  edge_d  = '0;
                end
              end
            end else if (!i_Enable[n]) begin
              state_d = ST_DRAIN;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (apply) begin
        div_act_d = div_pend_q;
        edge_d    = '0;
      end

      // A load on an application boundary becomes the next pending value.
      pend_d     = i_Load[n] | (pend_q & ~apply);
      div_pend_d = i_Load[n] ? i_Div[n*CNT_W +: CNT_W] : div_pend_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        div_act_q  <= DIV_RST;
        div_pend_q <= '0;
        pend_q     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
        edge_q     <= '0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        div_act_q  <= div_act_d;
        div_pend_q <= div_pend_d;
        pend_q     <= pend_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
        edge_q     <= edge_d;
      end
    end

    assign o_Clk[n]   = clk_q;
    assign o_Tick[n]  = tick_q;
    assign o_Ready[n] = (edge_q == READY_CNT);
  end

endmodule

// File: tb/tb_xclk_multi_divider.sv
// Scoreboard bench for xclk_multi_divider: a phase-countdown reference model
// predicts every output cycle; a monitor compares on the falling clock edge.
module tb_xclk_multi_divider;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 0;
  localparam int READY_EDGES = 2;

  typedef struct {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] ready;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       ld;
  logic [NUM_CH*CNT_W-1:0] dv;
  logic [NUM_CH-1:0]       o_clk, o_tick, o_ready;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: each channel is either off or in a phase of known level
  // with a number of cycles left; ratios change only when a high phase ends.
  int m_on[NUM_CH], m_lvl[NUM_CH], m_left[NUM_CH], m_ratio[NUM_CH];
  int m_pend[NUM_CH], m_pval[NUM_CH], m_edges[NUM_CH];

  xclk_multi_divider #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .READY_EDGES(READY_EDGES)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Load(ld), .i_Div(dv),
    .o_Clk(o_clk), .o_Tick(o_tick), .o_Ready(o_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  function automatic exp_t model_step();
    exp_t x;
    int   applied;
    for (int c = 0; c < NUM_CH; c++) begin
      x.tick[c] = 1'b0;
      applied   = 0;
      if (!rst_n) begin
        m_on[c] = 0; m_lvl[c] = 0; m_left[c] = 0; m_ratio[c] = DEFAULT_DIV;
        m_pend[c] = 0; m_pval[c] = 0; m_edges[c] = 0;
      end else begin
        if (m_on[c] == 0) begin
          if (en[c]) begin
            m_on[c] = 1;
            if (m_pend[c] != 0) begin m_ratio[c] = m_pval[c]; applied = 1; end
            m_lvl[c]  = 0;
            m_left[c] = m_ratio[c] + 1;
          end
        end else if (m_lvl[c] == 0 && !en[c]) begin
          m_on[c] = 0; m_edges[c] = 0;
        end else if (m_left[c] > 1) begin
          m_left[c]--;
        end else if (m_lvl[c] == 0) begin
          m_lvl[c] = 1; m_left[c] = m_ratio[c] + 1; x.tick[c] = 1'b1;
          if (m_edges[c] < READY_EDGES) m_edges[c]++;
        end else begin
          m_lvl[c] = 0;
          if (m_pend[c] != 0) begin m_ratio[c] = m_pval[c]; applied = 1; end
          m_left[c] = m_ratio[c] + 1;
          if (!en[c]) begin m_on[c] = 0; m_edges[c] = 0; end
        end
        if (applied != 0) m_edges[c] = 0;
        if (ld[c]) begin
          m_pend[c] = 1; m_pval[c] = int'(dv[c*CNT_W +: CNT_W]);
        end else if (applied != 0) begin
          m_pend[c] = 0;
        end
      end
      x.clk[c]   = (m_lvl[c] != 0);
      x.ready[c] = (m_edges[c] == READY_EDGES);
    end
    return x;
  endfunction

  // One clock: predict the state after the coming edge, then advance to
  // just past the next falling edge. Load strobes last a single cycle.
  task automatic step();
    exp_q.push_back(model_step());
    @(negedge clk);
    #1;
    ld = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int c, input int val);
    ld[c] = 1'b1;
    dv[c*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  // Advance until the model says channel c is at the given level with the
  // given cycles left in its phase; a bounded wait that counts as a failure if it expires.
  task automatic wait_phase(input int c, input int lvl, input int left);
    int n = 0;
    while (!(m_on[c] != 0 && m_lvl[c] == lvl && m_left[c] == left) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_phase ch%0d: phase lvl=%0d left=%0d not reached", c, lvl, left);
    end
  endtask

  // Monitor: one expectation per cycle, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("o_Clk", o_clk, e.clk);
        check("o_Tick", o_tick, e.tick);
        check("o_Ready", o_ready, e.ready);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = '1; ld = '0; dv = '0;
    // Reset held with enables high, then free-run at the default ratio.
    run(5);
    rst_n = 1'b1;
    run(12);

    // Program channel 1 while idle, then enable it.
    en = '0;
    run(3);
    load(1, 3);
    step();
    en[1] = 1'b1;
    run(24);

    // Glitch-free change: div 5 -> 1 loaded at cnt=2 of a high phase.
    load(0, 5);
    en[0] = 1'b1;
    step();
    wait_phase(0, 1, 4);
    load(0, 1);
    run(20);

    // Disable at cnt=1 of a div-4 high phase, let it drain, re-enable during drain.
    load(0, 4);
    wait_phase(0, 1, 4);
    en[0] = 1'b0;
    run(2);
    en[0] = 1'b1;
    run(24);
    wait_phase(0, 1, 4);
    en[0] = 1'b0;
    run(12);

    // Load landing exactly on the 1->0 toggle while another value is pending.
    en[0] = 1'b1;
    wait_phase(0, 1, 4);
    load(0, 2);
    step();
    wait_phase(0, 1, 1);
    load(0, 6);
    run(40);

    // One-cycle reset during a high phase, then load only channel 0.
    en = '1;
    wait_phase(0, 1, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(10);
    load(0, 2);
    run(20);

    // Randomized traffic on both channels.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(15) == 0) en[c] = ~en[c];
        if ($urandom_range(11) == 0) load(c, int'($urandom_range(5)));
      end
      rst_n = ($urandom_range(399) != 0);
      step();
    end
    rst_n = 1'b1;
    run(4);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
